// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the parametrised TinyCPU.
// - Opcode encodings (4-bit OP field).
// - Instruction field offset helpers, derived from DATA_W and AW.
// - Control FSM state encoding.
package tiny_cpu_pkg;

    localparam logic [3:0] OP_CLR = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;
    localparam logic [3:0] OP_NOP = 4'hB;

    // Instruction layout, MSB to LSB: {OP[3:0], RD[AW], RS[AW], IMM[DATA_W]}
    function automatic int unsigned op_lsb(input int unsigned data_w, input int unsigned aw);
        return data_w + 2 * aw;
    endfunction

    function automatic int unsigned rd_lsb(input int unsigned data_w, input int unsigned aw);
        return data_w + aw;
    endfunction

    function automatic int unsigned rs_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    typedef enum logic {
        StIdle,
        StMul
    } state_e;

endpackage

// File: rtl/tiny_mul_seq.sv
// Iterative shift-add multiplier, one partial-product step per clock.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 latch operand_a/operand_b, clear accumulator and counter
//   operand_a, operand_b  unsigned DATA_W-bit factors
//   busy                  a multiplication is in progress
//   done                  high during the cycle whose closing edge performs the last step
//   product               2*DATA_W-bit product; valid while done is high
module tiny_mul_seq #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   operand_a,
    input  logic [DATA_W-1:0]   operand_b,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    localparam int unsigned CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_W - 1);

    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] acc_step;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;

    // Accumulator value after the step taken at the next edge.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done     = 1'b0;
        if (start) begin
            mcand_d  = {{DATA_W{1'b0}}, operand_a};
            mplier_d = operand_b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign product = acc_step;

endmodule

// File: rtl/tiny_cpu_param.sv
// Parametrised TinyCPU: executes packed instructions against an NREGS-entry register
// file, a Result register and Z/C flags; MUL is iterative and takes DATA_W cycles.
// Ports:
//   Clk, Rst_n        clock, asynchronous active-low reset
//   In                instruction {OP[3:0], RD[AW], RS[AW], IMM[DATA_W]}
//   In_valid/In_ready instruction handshake; In_ready high whenever the CPU is idle
//   Result            result register
//   Flag_z, Flag_c    zero/equal and carry/borrow/less-than flags
//   Done              one-cycle pulse per retired instruction
//   Err               sticky illegal-opcode flag (cleared by CLR or reset)
//   Dbg_sel/Dbg_data  combinational register-file read port
module tiny_cpu_param
    import tiny_cpu_pkg::*;
#(
    parameter int unsigned  DATA_W  = 8,
    parameter int unsigned  NREGS   = 4,
    localparam int unsigned AW      = $clog2(NREGS),
    localparam int unsigned INSTR_W = 4 + 2 * AW + DATA_W
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [INSTR_W-1:0] In,
    input  logic               In_valid,
    output logic               In_ready,
    output logic [DATA_W-1:0]  Result,
    output logic               Flag_z,
    output logic               Flag_c,
    output logic               Done,
    output logic               Err,
    input  logic [AW-1:0]      Dbg_sel,
    output logic [DATA_W-1:0]  Dbg_data
);

    localparam int unsigned OP_LSB = op_lsb(DATA_W, AW);
    localparam int unsigned RD_LSB = rd_lsb(DATA_W, AW);
    localparam int unsigned RS_LSB = rs_lsb(DATA_W);

    // Instruction fields
    logic [3:0]        op;
    logic [AW-1:0]     rd;
    logic [AW-1:0]     rs;
    logic [DATA_W-1:0] imm;

    assign op  = In[OP_LSB +: 4];
    assign rd  = In[RD_LSB +: AW];
    assign rs  = In[RS_LSB +: AW];
    assign imm = In[DATA_W-1:0];

    // Architectural state
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] result_q, result_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    state_e            state_q, state_d;

    // Datapath
    logic [DATA_W-1:0]   op_a, op_b;
    logic [DATA_W:0]     sum;
    logic                accept;
    logic                alu_wr;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                mul_start;
    logic                mul_busy;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;

    assign op_a   = regs_q[rd];
    assign op_b   = regs_q[rs];
    assign sum    = {1'b0, op_a} + {1'b0, op_b};
    assign accept = In_valid && In_ready;

    tiny_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .start     (mul_start),
        .operand_a (op_a),
        .operand_b (op_b),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product)
    );

    always_comb begin
        regs_d    = regs_q;
        result_d  = result_q;
        z_d       = z_q;
        c_d       = c_q;
        err_d     = err_q;
        done_d    = 1'b0;
        state_d   = state_q;
        mul_start = 1'b0;
        alu_wr    = 1'b0;
        alu_res   = '0;
        alu_c     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    done_d = 1'b1;
                    unique case (op)
                        OP_CLR: begin
                            regs_d   = '{default: '0};
                            result_d = '0;
                            z_d      = 1'b0;
                            c_d      = 1'b0;
                            err_d    = 1'b0;
                        end
                        OP_LDI: regs_d[rd] = imm;
                        OP_MOV: regs_d[rd] = result_q;
                        OP_ADD: begin
                            alu_wr  = 1'b1;
                            alu_res = sum[DATA_W-1:0];
                            alu_c   = sum[DATA_W];
                        end
                        OP_SUB: begin
                            alu_wr  = 1'b1;
                            alu_res = op_a - op_b;
                            alu_c   = (op_a < op_b);
                        end
                        OP_XOR: begin
                            alu_wr  = 1'b1;
                            alu_res = op_a ^ op_b;
                        end
                        OP_AND: begin
                            alu_wr  = 1'b1;
                            alu_res = op_a & op_b;
                        end
                        OP_SHR: begin
                            alu_wr  = 1'b1;
                            alu_res = {1'b0, op_a[DATA_W-1:1]};
                            alu_c   = op_a[0];
                        end
                        OP_SHL: begin
                            alu_wr  = 1'b1;
                            alu_res = {op_a[DATA_W-2:0], 1'b0};
                            alu_c   = op_a[DATA_W-1];
                        end
                        OP_CMP: begin
                            z_d = (op_a == op_b);
                            c_d = (op_a < op_b);
                        end
                        OP_MUL: begin
                            // Retires later, from StMul.
                            mul_start = 1'b1;
                            done_d    = 1'b0;
                            state_d   = StMul;
                        end
                        OP_NOP: ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StMul: begin
                // In_valid is ignored here; the source holds the next instruction.
                if (mul_done) begin
                    alu_wr  = 1'b1;
                    alu_res = mul_product[DATA_W-1:0];
                    alu_c   = |mul_product[2*DATA_W-1:DATA_W];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (alu_wr) begin
            result_d = alu_res;
            c_d      = alu_c;
            z_d      = (alu_res == '0);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            regs_q   <= '{default: '0};
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            state_q  <= StIdle;
        end else begin
            regs_q   <= regs_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
            err_q    <= err_d;
            done_q   <= done_d;
            state_q  <= state_d;
        end
    end

    // The control FSM and the multiplier must agree on when a MUL is in flight.
    assert property (@(posedge Clk) disable iff (!Rst_n) (state_q == StMul) == mul_busy);

    assign In_ready = (state_q == StIdle);
    assign Result   = result_q;
    assign Flag_z   = z_q;
    assign Flag_c   = c_q;
    assign Done     = done_q;
    assign Err      = err_q;
    assign Dbg_data = regs_q[Dbg_sel];

endmodule
